// File: rtl/ui_game_pkg.sv
// rtl/ui_game_pkg.sv - shared board geometry, turn FSM states and die helpers
// Purpose: constants shared with the renderer and test top, the turn_controller
//          state type, and the LFSR / die-roll helper functions.
// Ports:   none (package).
package ui_game_pkg;

   localparam int TILE_SPACING = 60;   // pixels per step
   localparam int START_X      = 20;   // start x of both players
   localparam int MAX_X        = 620;  // flag x: clamp limit and win position
   localparam logic [7:0] LFSR_SEED = 8'hA5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CALC  = 3'd1,
      MOVE  = 3'd2,
      CHECK = 3'd3,
      OVER  = 3'd4
   } turn_state_t;

   // 8-bit Fibonacci LFSR, taps 8,6,5,4; a non-zero seed never reaches zero.
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
   endfunction

   // Die roll 1..3 from the current LFSR value.
   function automatic logic [1:0] roll_step(input logic [7:0] cur);
      logic [7:0] rem;
      rem = cur % 8'd3;
      return rem[1:0] + 2'd1;
   endfunction

endpackage

// File: rtl/turn_controller_if.sv
// rtl/turn_controller_if.sv - move handshake between turn sequencer and renderer
// Purpose: per-player target_x / move_start request and turn_done completion.
// Ports:   master = turn sequencer (drives targets and move_start),
//          slave  = renderer (drives turn_done).
interface turn_controller_if;
   logic [9:0] player1_target_x;
   logic       player1_move_start;
   logic       player1_turn_done;
   logic [9:0] player2_target_x;
   logic       player2_move_start;
   logic       player2_turn_done;

   modport master (
      output player1_target_x, player1_move_start,
      output player2_target_x, player2_move_start,
      input  player1_turn_done, player2_turn_done
   );

   modport slave (
      input  player1_target_x, player1_move_start,
      input  player2_target_x, player2_move_start,
      output player1_turn_done, player2_turn_done
   );
endinterface

// File: rtl/turn_controller_debounce.sv
// rtl/turn_controller_debounce.sv - button synchronizer, debouncer and press pulse
// Purpose: 2-flop synchronizer, stability counter, 1-cycle rising-edge pulse.
// Ports:   clk_100mhz, btn_reset (async, active-high), btn_raw (raw button),
//          btn_pulse (1 cycle on the debounced rising edge).
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk_100mhz,
   input  logic btn_reset,
   input  logic btn_raw,
   output logic btn_pulse
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      // Count consecutive samples that disagree with the accepted level;
      // any agreeing sample restarts the count.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      pulse_d = level_d & ~level_q;
   end

   always_ff @(posedge clk_100mhz or posedge btn_reset) begin
      if (btn_reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_pulse = pulse_q;
endmodule

// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - game-turn sequencer feeding the UI renderer
// Purpose: debounces buttons, rolls or forces a 1..3 step count, drives the
//          active player's target_x/move_start, waits for turn_done,
//          alternates players and declares a winner at the flag.
// Ports:   clk_100mhz, btn_reset (async, active-high); btn_roll, btnL, btnU,
//          btnR raw buttons; rnd renderer handshake (master side);
//          active_player, dice_value, game_over, winner status outputs.
module turn_controller
   import ui_game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                     clk_100mhz,
   input  logic                     btn_reset,
   input  logic                     btn_roll,
   input  logic                     btnL,
   input  logic                     btnU,
   input  logic                     btnR,
   turn_controller_if.master        rnd,
   output logic                     active_player,
   output logic [1:0]               dice_value,
   output logic                     game_over,
   output logic                     winner
);
   logic roll_pulse, l_pulse, u_pulse, r_pulse;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_roll (
      .clk_100mhz(clk_100mhz), .btn_reset(btn_reset), .btn_raw(btn_roll), .btn_pulse(roll_pulse));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
      .clk_100mhz(clk_100mhz), .btn_reset(btn_reset), .btn_raw(btnL), .btn_pulse(l_pulse));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (
      .clk_100mhz(clk_100mhz), .btn_reset(btn_reset), .btn_raw(btnU), .btn_pulse(u_pulse));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
      .clk_100mhz(clk_100mhz), .btn_reset(btn_reset), .btn_raw(btnR), .btn_pulse(r_pulse));

   turn_state_t state_q, state_d;
   logic [9:0]  p1_tx_q, p1_tx_d, p2_tx_q, p2_tx_d;
   logic [9:0]  p1_pos_q, p1_pos_d, p2_pos_q, p2_pos_d;
   logic        p1_ms_q, p1_ms_d, p2_ms_q, p2_ms_d;
   logic        active_q, active_d;
   logic [1:0]  dice_q, dice_d;
   logic        over_q, over_d;
   logic        winner_q, winner_d;
   logic [7:0]  lfsr_q, lfsr_d;
   // [0],[1] synchronize the 25 MHz turn_done; [2] is the edge-detect history.
   logic [2:0]  p1_done_q, p1_done_d, p2_done_q, p2_done_d;

   logic        p1_done_pulse, p2_done_pulse, act_done;
   logic [9:0]  cur_pos;
   logic [10:0] next_x;
   logic [9:0]  new_tx;

   assign p1_done_pulse = p1_done_q[1] & ~p1_done_q[2];
   assign p2_done_pulse = p2_done_q[1] & ~p2_done_q[2];
   assign act_done      = active_q ? p2_done_pulse : p1_done_pulse;
   assign cur_pos       = active_q ? p2_pos_q : p1_pos_q;
   assign next_x        = {1'b0, cur_pos} + 11'(dice_q) * 11'(TILE_SPACING);
   assign new_tx        = (next_x > 11'(MAX_X)) ? 10'(MAX_X) : next_x[9:0];

   always_comb begin
      state_d   = state_q;
      p1_tx_d   = p1_tx_q;
      p2_tx_d   = p2_tx_q;
      p1_pos_d  = p1_pos_q;
      p2_pos_d  = p2_pos_q;
      p1_ms_d   = p1_ms_q;
      p2_ms_d   = p2_ms_q;
      active_d  = active_q;
      dice_d    = dice_q;
      over_d    = over_q;
      winner_d  = winner_q;
      lfsr_d    = lfsr_next(lfsr_q);
      p1_done_d = {p1_done_q[1:0], rnd.player1_turn_done};
      p2_done_d = {p2_done_q[1:0], rnd.player2_turn_done};

      case (state_q)
         IDLE: begin
            // Fixed priority; lower-priority simultaneous pulses are dropped.
            if (l_pulse) begin
               dice_d  = 2'd1;
               state_d = CALC;
            end else if (u_pulse) begin
               dice_d  = 2'd2;
               state_d = CALC;
            end else if (r_pulse) begin
               dice_d  = 2'd3;
               state_d = CALC;
            end else if (roll_pulse) begin
               dice_d  = roll_step(lfsr_q);
               state_d = CALC;
            end
         end
         CALC: begin
            // move_start is raised together with target_x so the renderer
            // never sees the request before the destination is stable.
            if (active_q) begin
               p2_tx_d = new_tx;
               p2_ms_d = 1'b1;
            end else begin
               p1_tx_d = new_tx;
               p1_ms_d = 1'b1;
            end
            state_d = MOVE;
         end
         MOVE: begin
            if (act_done) begin
               if (active_q) begin
                  p2_ms_d  = 1'b0;
                  p2_pos_d = p2_tx_q;
               end else begin
                  p1_ms_d  = 1'b0;
                  p1_pos_d = p1_tx_q;
               end
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (cur_pos == 10'(MAX_X)) begin
               over_d   = 1'b1;
               winner_d = active_q;
               state_d  = OVER;
            end else begin
               active_d = ~active_q;
               state_d  = IDLE;
            end
         end
         OVER: begin
            p1_ms_d = 1'b0;
            p2_ms_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_100mhz or posedge btn_reset) begin
      if (btn_reset) begin
         state_q   <= IDLE;
         p1_tx_q   <= 10'(START_X);
         p2_tx_q   <= 10'(START_X);
         p1_pos_q  <= 10'(START_X);
         p2_pos_q  <= 10'(START_X);
         p1_ms_q   <= 1'b0;
         p2_ms_q   <= 1'b0;
         active_q  <= 1'b0;
         dice_q    <= 2'd0;
         over_q    <= 1'b0;
         winner_q  <= 1'b0;
         lfsr_q    <= LFSR_SEED;
         p1_done_q <= 3'b000;
         p2_done_q <= 3'b000;
      end else begin
         state_q   <= state_d;
         p1_tx_q   <= p1_tx_d;
         p2_tx_q   <= p2_tx_d;
         p1_pos_q  <= p1_pos_d;
         p2_pos_q  <= p2_pos_d;
         p1_ms_q   <= p1_ms_d;
         p2_ms_q   <= p2_ms_d;
         active_q  <= active_d;
         dice_q    <= dice_d;
         over_q    <= over_d;
         winner_q  <= winner_d;
         lfsr_q    <= lfsr_d;
         p1_done_q <= p1_done_d;
         p2_done_q <= p2_done_d;
      end
   end

   assign rnd.player1_target_x   = p1_tx_q;
   assign rnd.player1_move_start = p1_ms_q;
   assign rnd.player2_target_x   = p2_tx_q;
   assign rnd.player2_move_start = p2_ms_q;
   assign active_player          = active_q;
   assign dice_value             = dice_q;
   assign game_over              = over_q;
   assign winner                 = winner_q;
endmodule

// File: tb/tb_turn_controller.sv
// tb/tb_turn_controller.sv - self-checking bench for turn_controller
module tb_turn_controller;
   import ui_game_pkg::*;

   logic       clk_100mhz = 1'b0;
   logic       btn_reset  = 1'b0;
   logic       btn_roll   = 1'b0;
   logic       btnL       = 1'b0;
   logic       btnU       = 1'b0;
   logic       btnR       = 1'b0;
   logic       active_player;
   logic [1:0] dice_value;
   logic       game_over;
   logic       winner;

   turn_controller_if rif();

   turn_controller #(.DEBOUNCE_CYCLES(4)) dut (
      .clk_100mhz   (clk_100mhz),
      .btn_reset    (btn_reset),
      .btn_roll     (btn_roll),
      .btnL         (btnL),
      .btnU         (btnU),
      .btnR         (btnR),
      .rnd          (rif),
      .active_player(active_player),
      .dice_value   (dice_value),
      .game_over    (game_over),
      .winner       (winner)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   int checks   = 0;
   int failures = 0;

   // Reference LFSR with two cycles of history: at the negedge after the
   // cycle in which move_start rises, h2 holds the value the FSM sampled.
   logic [7:0] lfsr_m, h1, h2;
   always @(posedge clk_100mhz or posedge btn_reset) begin
      if (btn_reset) begin
         lfsr_m <= 8'hA5;
         h1     <= 8'hA5;
         h2     <= 8'hA5;
      end else begin
         h2     <= h1;
         h1     <= lfsr_m;
         lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
      end
   end

   int pos_m[2];
   int tgt_m[2];
   int active_m;
   int over_m;

   typedef struct {
      int pre;      // 0 none, 1 bounce test first, 2 reset then wait for LFSR=A5
      int code;     // 0 L, 1 U, 2 R, 3 roll, 4 L+R together
      int dice;
      int target;
      int over;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic ms_of(input int p);
      return (p != 0) ? rif.player2_move_start : rif.player1_move_start;
   endfunction

   function automatic logic [9:0] tgt_of(input int p);
      return (p != 0) ? rif.player2_target_x : rif.player1_target_x;
   endfunction

   task automatic set_btn(input int code, input logic v);
      case (code)
         0: btnL = v;
         1: btnU = v;
         2: btnR = v;
         3: btn_roll = v;
         default: begin btnL = v; btnR = v; end
      endcase
   endtask

   task automatic set_done(input int p, input logic v);
      if (p != 0) rif.player2_turn_done = v;
      else        rif.player1_turn_done = v;
   endtask

   task automatic do_reset();
      @(negedge clk_100mhz);
      btn_reset = 1'b1;
      repeat (2) @(negedge clk_100mhz);
      btn_reset = 1'b0;
      pos_m[0] = START_X; pos_m[1] = START_X;
      tgt_m[0] = START_X; tgt_m[1] = START_X;
      active_m = 0;
      over_m   = 0;
   endtask

   // One full turn: press (10 cycles), check the request, complete it.
   // Negative expectations are derived from the reference model.
   task automatic do_turn(input int code, input int exp_d, input int exp_t, input int exp_o);
      int p, q, n, d, t, o;
      logic seen;
      p = active_m;
      q = 1 - p;
      seen = 1'b0;
      set_btn(code, 1'b1);
      n = 0;
      while (n < 40) begin
         @(negedge clk_100mhz);
         n++;
         if (n == 10) set_btn(code, 1'b0);
         if (ms_of(p)) begin
            seen = 1'b1;
            break;
         end
      end
      chk("move_start_rise", 32'(seen), 32'd1);
      if (!seen) begin
         set_btn(code, 1'b0);
         return;
      end
      d = (exp_d >= 0) ? exp_d : (int'(h2) % 3) + 1;
      t = (exp_t >= 0) ? exp_t : ((pos_m[p] + d * TILE_SPACING > MAX_X) ? MAX_X : pos_m[p] + d * TILE_SPACING);
      o = (exp_o >= 0) ? exp_o : ((t == MAX_X) ? 1 : 0);
      chk("dice_value", 32'(dice_value), 32'(d));
      chk("active_target", 32'(tgt_of(p)), 32'(t));
      chk("inactive_target", 32'(tgt_of(q)), 32'(tgt_m[q]));
      chk("inactive_move_start", 32'(ms_of(q)), 32'd0);
      tgt_m[p] = t;
      if (n < 10) begin
         repeat (10 - n) @(negedge clk_100mhz);
         set_btn(code, 1'b0);
      end
      set_done(p, 1'b1);
      n = 0;
      while (n < 20) begin
         @(negedge clk_100mhz);
         n++;
         if (n == 4) set_done(p, 1'b0);
         if (!ms_of(p)) break;
      end
      if (n < 4) begin
         repeat (4 - n) @(negedge clk_100mhz);
         set_done(p, 1'b0);
      end
      chk("move_start_drop", 32'(ms_of(p)), 32'd0);
      repeat (2) @(negedge clk_100mhz);
      pos_m[p] = t;
      chk("game_over", 32'(game_over), 32'(o));
      if (o != 0) begin
         chk("winner", 32'(winner), 32'(p));
         over_m = 1;
      end else begin
         chk("active_toggle", 32'(active_player), 32'(q));
         active_m = q;
      end
      chk("inactive_target_after", 32'(tgt_of(q)), 32'(tgt_m[q]));
   endtask

   // Watches both move_start lines for a number of cycles.
   task automatic watch_no_move(input string name, input int cycles);
      logic any;
      any = 1'b0;
      repeat (cycles) begin
         @(negedge clk_100mhz);
         if (rif.player1_move_start || rif.player2_move_start) any = 1'b1;
      end
      chk(name, 32'(any), 32'd0);
   endtask

   logic [7:0] a5_pre;

   initial begin
      rif.player1_turn_done = 1'b0;
      rif.player2_turn_done = 1'b0;

      // LFSR value six clocks before A5: a roll pressed then is sampled at A5.
      a5_pre = 8'hA5;
      repeat (249) a5_pre = lfsr_next(a5_pre);

      vecs[0]  = '{0, 0, 1, 80,  0};
      vecs[1]  = '{0, 1, 2, 140, 0};
      vecs[2]  = '{1, 4, 1, 140, 0};
      vecs[3]  = '{0, 2, 3, 320, 0};
      vecs[4]  = '{0, 2, 3, 320, 0};
      vecs[5]  = '{0, 0, 1, 380, 0};
      vecs[6]  = '{0, 2, 3, 500, 0};
      vecs[7]  = '{0, 0, 1, 440, 0};
      vecs[8]  = '{0, 2, 3, 620, 1};
      vecs[9]  = '{2, 3, 1, 80,  0};
      vecs[10] = '{0, 2, 3, 200, 0};
      vecs[11] = '{0, 0, 1, 140, 0};
      vecs[12] = '{0, 2, 3, 380, 0};
      vecs[13] = '{0, 0, 1, 200, 0};
      vecs[14] = '{0, 2, 3, 560, 0};
      vecs[15] = '{0, 0, 1, 260, 0};
      vecs[16] = '{0, 0, 1, 620, 1};

      do_reset();
      @(negedge clk_100mhz);
      chk("rst_p1_target", 32'(rif.player1_target_x), 32'd20);
      chk("rst_p2_target", 32'(rif.player2_target_x), 32'd20);
      chk("rst_move_start", 32'({rif.player1_move_start, rif.player2_move_start}), 32'd0);
      chk("rst_active", 32'(active_player), 32'd0);
      chk("rst_dice", 32'(dice_value), 32'd0);
      chk("rst_over_winner", 32'({game_over, winner}), 32'd0);

      for (int i = 0; i < 17; i++) begin
         if (vecs[i].pre == 1) begin
            for (int k = 0; k < 20; k++) begin
               if (k % 2 == 0) btnU = ~btnU;
               @(negedge clk_100mhz);
            end
            btnU = 1'b0;
            watch_no_move("bounce_no_move", 15);
            chk("bounce_active", 32'(active_player), 32'(active_m));
         end else if (vecs[i].pre == 2) begin
            do_reset();
            for (int k = 0; k < 300; k++) begin
               if (lfsr_m == a5_pre) break;
               @(negedge clk_100mhz);
            end
         end
         do_turn(vecs[i].code, vecs[i].dice, vecs[i].target, vecs[i].over);
         if (i == 8) begin
            btnL = 1'b1;
            repeat (10) @(negedge clk_100mhz);
            btnL = 1'b0;
            btnR = 1'b1;
            repeat (10) @(negedge clk_100mhz);
            btnR = 1'b0;
            watch_no_move("over_no_move", 20);
            chk("over_held", 32'({game_over, winner}), 32'b10);
         end
      end

      for (int r = 0; r < 20; r++) begin
         if (over_m != 0) do_reset();
         do_turn(3, -1, -1, -1);
         chk("roll_range", 32'((dice_value >= 2'd1) && (dice_value <= 2'd3)), 32'd1);
      end

      // Reset while player 2 is mid-move.
      do_reset();
      do_turn(0, 1, 80, 0);
      btnU = 1'b1;
      begin
         logic seen2;
         seen2 = 1'b0;
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk_100mhz);
            if (k == 10) btnU = 1'b0;
            if (rif.player2_move_start) begin
               seen2 = 1'b1;
               break;
            end
         end
         chk("p2_move_start_rise", 32'(seen2), 32'd1);
      end
      repeat (10) @(negedge clk_100mhz);
      btnU = 1'b0;
      #2 btn_reset = 1'b1;
      #1 chk("reset_drops_move_start", 32'(rif.player2_move_start), 32'd0);
      repeat (2) @(negedge clk_100mhz);
      btn_reset = 1'b0;
      pos_m[0] = START_X; pos_m[1] = START_X;
      tgt_m[0] = START_X; tgt_m[1] = START_X;
      active_m = 0;
      over_m   = 0;
      @(negedge clk_100mhz);
      chk("post_rst_targets", 32'({rif.player1_target_x, rif.player2_target_x}), 32'({10'd20, 10'd20}));
      chk("post_rst_active", 32'(active_player), 32'd0);
      rif.player2_turn_done = 1'b1;
      repeat (4) @(negedge clk_100mhz);
      rif.player2_turn_done = 1'b0;
      watch_no_move("stale_done_no_move", 10);
      chk("stale_done_p2_target", 32'(rif.player2_target_x), 32'd20);
      chk("stale_done_active", 32'(active_player), 32'd0);
      do_turn(0, 1, 80, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
